// File: rtl/run_pkg.sv
// rtl/run_pkg.sv - shared state encoding and constants for the run generator and its sequence detector
package run_pkg;

    localparam int LEN_W_DEFAULT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The downstream detector compares each emitted bit with the one before it.
    localparam int SEQ_PAIR_LEN = 2;

endpackage

// File: rtl/run_gen.sv
// rtl/run_gen.sv - run-length token to serial bit stream expander with one-deep pending slot
module run_gen
    import run_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic [LEN_W-1:0] in_len,
    output logic             dout,
    output logic             dout_valid,
    output logic             run_last,
    output logic             err_len
);

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] CNT_TWO = LEN_W'(2);

    state_t           state;
    logic             pend_valid;
    logic             pend_bit;
    logic [LEN_W-1:0] pend_len;
    logic [LEN_W-1:0] cnt;

    logic             accept;
    logic             tok_ok;
    logic             final_bit;
    logic             load_now;
    logic             load_bit;
    logic [LEN_W-1:0] load_len;

    assign in_ready = !pend_valid;

    // dout itself holds the active run's bit; cnt counts bits left including the one on dout.
    always_comb begin
        accept    = in_valid && in_ready;
        tok_ok    = accept && (in_len != '0);
        final_bit = (state == RUN) && (cnt == CNT_ONE);
        load_bit  = pend_valid ? pend_bit : in_bit;
        load_len  = pend_valid ? pend_len : in_len;
        load_now  = ((state == IDLE) && tok_ok) ||
                    (final_bit && (pend_valid || tok_ok));
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            pend_bit   <= 1'b0;
            pend_len   <= '0;
            cnt        <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            run_last   <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            if (accept && (in_len == '0)) begin
                err_len <= 1'b1;
            end

            if (load_now) begin
                // Pending (if any) always wins; otherwise the token arriving this cycle.
                state      <= RUN;
                dout       <= load_bit;
                dout_valid <= 1'b1;
                cnt        <= load_len;
                run_last   <= (load_len == CNT_ONE);
                pend_valid <= 1'b0;
            end else if ((state == RUN) && !final_bit) begin
                cnt      <= cnt - CNT_ONE;
                run_last <= (cnt == CNT_TWO);
                if (tok_ok) begin
                    pend_valid <= 1'b1;
                    pend_bit   <= in_bit;
                    pend_len   <= in_len;
                end
            end else begin
                state      <= IDLE;
                dout       <= 1'b0;
                dout_valid <= 1'b0;
                run_last   <= 1'b0;
                cnt        <= '0;
            end
        end
    end

endmodule

// File: doc/run_gen.md
RUN_GEN -- requirements
Module: run_gen

Interface
REQ-001 Parameter LEN_W, default 4, SHALL set the width of the run-length field.
REQ-002 ck  input  1  SHALL be the clock; all state SHALL update on posedge ck.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 in_valid  input  1  SHALL indicate a run token is presented.
REQ-005 in_ready  output  1  SHALL indicate the block accepts a token this cycle.
REQ-006 in_bit  input  1  SHALL be the bit value of the run.
REQ-007 in_len  input  LEN_W  SHALL be the run length in bits, 1 to 2^LEN_W-1.
REQ-008 dout  output  1  SHALL be the serial output bit.
REQ-009 dout_valid  output  1  SHALL mark cycles in which dout carries a run bit.
REQ-010 run_last  output  1  SHALL pulse with the last bit of each run.
REQ-011 err_len  output  1  SHALL be a sticky flag for a zero-length token.

Function
REQ-012 A token SHALL be accepted on any posedge where in_valid and in_ready are both high.
REQ-013 Storage SHALL be one active run (bit, down-counter) plus one pending token register (bit, len, pend_valid).
REQ-014 in_ready SHALL equal !pend_valid, with no combinational path from in_valid.
REQ-015 The state machine SHALL have exactly two states, IDLE and RUN.
REQ-016 In IDLE with pend_valid low, an accepted token SHALL load directly into the active run, enter RUN, and drive dout_valid on the next cycle (latency 1).
REQ-017 In RUN, each cycle SHALL emit dout=active bit with dout_valid=1 and decrement the counter.
REQ-018 On the final bit (counter==1), run_last SHALL be 1.
REQ-019 On the final bit with pend_valid high, the pending token SHALL load next cycle with no gap, and pend_valid SHALL clear.
REQ-020 On the final bit with pend_valid low and a token accepted in the same cycle, the accepted token SHALL load directly into the active run with no gap.
REQ-021 On the final bit with no pending and no accepted token, the FSM SHALL return to IDLE.
REQ-022 In RUN, when not on the final bit, an accepted token SHALL go to the pending register.
REQ-023 A token with in_len==0 SHALL be accepted and discarded, SHALL set err_len, and SHALL emit nothing.
REQ-024 Runs SHALL be emitted in acceptance order, and consecutive equal-bit runs SHALL be concatenated seamlessly.
REQ-025 In IDLE, dout SHALL be 0, and dout_valid and run_last SHALL be 0.
REQ-026 The counter SHALL be LEN_W bits and SHALL never wrap below 1 while in RUN.
REQ-027 dout, dout_valid and run_last SHALL be registered outputs.

Reset
REQ-028 With rst high at posedge ck, the FSM SHALL go to IDLE, pend_valid to 0, the counter to 0, and err_len to 0.
REQ-029 Reset SHALL set dout, dout_valid and run_last to 0, and the in_ready output to 1 on the following cycle.
REQ-030 Reset mid-run SHALL abort the active and pending runs without emitting further bits, and tokens presented during rst SHALL NOT be accepted.

Structure
REQ-031 State encodings IDLE/RUN and the default LEN_W SHALL reside in the shared package run_pkg, together with the constants used by the sequence detector.
REQ-032 The implementation SHALL be a single module with no sub-modules.

Verification
REQ-033 Token (1,3) in IDLE -> dout_valid=1 for 3 cycles starting 1 cycle after acceptance, dout=1,1,1, run_last on the third bit.
REQ-034 Tokens (0,2), (1,1), (0,4) back-to-back -> continuous stream 0,0,1,0,0,0,0 with no idle gap; run_last on bits 2, 3 and 7.
REQ-035 Token (1,15) with a second token held valid -> in_ready low while pending is full, high again the cycle after the pending token loads.
REQ-036 Token (0,0) -> no output, err_len=1 and held until rst.
REQ-037 rst asserted on the 2nd bit of (1,5) with (0,2) pending -> the next cycle has dout_valid=0, in IDLE, in_ready=1, and no further bits are emitted.
REQ-038 Loopback into the sequence detector with (1,2),(0,3) -> the detector flags every equal-adjacent bit pair in the emitted stream 1,1,0,0,0.
